uart_tx_buffer: RTL and testbench

- Transmit-side write buffer between the core data bus and the memory-mapped uart block.
- Accepts byte writes from the core into a FIFO without waiting on the serial line.
- Drains the FIFO into the uart through its write_request/write_response handshake.
- Exposes status and control registers, and a level interrupt when the FIFO empties.

---
 rtl/uart_tx_buffer_pkg.sv | 40 ++++
 rtl/uart_tx_buffer_fifo.sv | 57 +++++
 rtl/uart_tx_buffer.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_buffer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffer_pkg.sv
// Shared definitions for the uart transmit buffer: register map, status/control
// bit positions and the drain state machine encoding.
package uart_tx_buffer_pkg;

  localparam logic [31:0] DATA_OFS   = 32'h0;
  localparam logic [31:0] STATUS_OFS = 32'h4;
  localparam logic [31:0] CTRL_OFS   = 32'h8;

  localparam int ST_EMPTY_BIT  = 8;
  localparam int ST_FULL_BIT   = 9;
  localparam int ST_OVF_BIT    = 10;
  localparam int ST_BUSY_BIT   = 11;
  localparam int ST_IRQ_EN_BIT = 12;

  localparam int CTRL_FLUSH_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  typedef enum logic {
    IDLE,
    REQ
  } drain_state_t;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL
  } reg_sel_t;

  // Full 32-bit match; anything else is an unmapped (but still granted) access.
  function automatic reg_sel_t decode_reg(input logic [31:0] addr, input logic [31:0] base);
    reg_sel_t sel;
    sel = REG_NONE;
    if (addr == base + DATA_OFS)        sel = REG_DATA;
    else if (addr == base + STATUS_OFS) sel = REG_STATUS;
    else if (addr == base + CTRL_OFS)   sel = REG_CTRL;
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// Generic synchronous FIFO with a clear that overrides push and pop.
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign head_o  = r_mem[r_rd_ptr];

  assign w_push = push_i && !full_o;
  assign w_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage carries no reset; an entry is only visible once counted.
  always_ff @(posedge clk_i) begin
    if (w_push && !clear_i) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit write buffer: bus register decode, overflow/irq flags and the
// drain state machine that feeds FIFO bytes to the uart handshake.
//
// state | meaning
// IDLE  | no uart request outstanding; leaves when the FIFO holds a byte
// REQ   | uart_wreq_o high with the FIFO head; pops and returns on uart_wack_i
module uart_tx_buffer
  import uart_tx_buffer_pkg::*;
#(
  parameter int          DEPTH              = 16,
  parameter logic [31:0] BASE_ADDRESS       = 32'h2000_0000,
  parameter logic [31:0] UART_WRITE_ADDRESS = 32'h1000_0000,
  parameter bit          STALL_ON_FULL      = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        bus_req_i,
  input  logic        bus_we_i,
  input  logic [31:0] bus_addr_i,
  input  logic [31:0] bus_wdata_i,
  output logic        bus_gnt_o,
  output logic        bus_rvalid_o,
  output logic [31:0] bus_rdata_o,
  output logic [31:0] uart_addr_o,
  output logic [7:0]  uart_wdata_o,
  output logic        uart_wreq_o,
  input  logic        uart_wack_i,
  output logic        empty_irq_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  drain_state_t r_state;
  drain_state_t w_state_nxt;
  reg_sel_t     w_sel;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;

  logic w_data_wr;
  logic w_status_rd;
  logic w_ctrl_wr;
  logic w_flush_req;
  logic w_flush_now;
  logic w_push;
  logic w_pop;
  logic w_clear;
  logic w_wreq;

  logic        r_flush_pending;
  logic        r_ovf;
  logic        r_irq_en;
  logic        r_irq;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [31:0] w_rdata_nxt;
  logic [31:0] w_status;
  logic        w_unused;

  assign w_sel = decode_reg(bus_addr_i, BASE_ADDRESS);

  assign bus_gnt_o = bus_req_i &&
                     !(STALL_ON_FULL && bus_we_i && (w_sel == REG_DATA) && w_full);

  assign w_data_wr   = bus_gnt_o && bus_we_i && (w_sel == REG_DATA);
  assign w_status_rd = bus_gnt_o && !bus_we_i && (w_sel == REG_STATUS);
  assign w_ctrl_wr   = bus_gnt_o && bus_we_i && (w_sel == REG_CTRL);
  assign w_flush_req = w_ctrl_wr && bus_wdata_i[CTRL_FLUSH_BIT];

  assign w_pop       = (r_state == REQ) && uart_wack_i;
  assign w_flush_now = w_flush_req && (r_state == IDLE);
  // Full is judged on the pre-pop state, so a same-cycle pop never frees a slot.
  assign w_push      = w_data_wr && !w_full && !w_flush_now;
  // A flush seen during REQ lets the in-flight byte finish, then drops the rest.
  assign w_clear     = w_flush_now || (w_pop && (r_flush_pending || w_flush_req));

  assign w_unused = ^bus_wdata_i[31:8];

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (w_clear),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (bus_wdata_i[7:0]),
    .head_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wreq      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && !w_flush_now) w_state_nxt = REQ;
      end
      REQ: begin
        w_wreq = 1'b1;
        if (uart_wack_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Driven straight from the state register so reset drops the request at once.
  assign uart_wreq_o  = w_wreq;
  assign uart_wdata_o = w_wreq ? w_head : 8'h00;
  assign uart_addr_o  = UART_WRITE_ADDRESS;

  always_comb begin
    w_status                = '0;
    w_status[7:0]           = 8'(w_count);
    w_status[ST_EMPTY_BIT]  = w_empty;
    w_status[ST_FULL_BIT]   = w_full;
    w_status[ST_OVF_BIT]    = r_ovf;
    w_status[ST_BUSY_BIT]   = (r_state != IDLE);
    w_status[ST_IRQ_EN_BIT] = r_irq_en;
  end

  always_comb begin
    w_rdata_nxt = '0;
    if (bus_gnt_o && !bus_we_i) begin
      case (w_sel)
        REG_STATUS: w_rdata_nxt = w_status;
        REG_CTRL:   w_rdata_nxt[CTRL_IRQ_EN_BIT] = r_irq_en;
        default:    w_rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid        <= 1'b0;
      r_rdata         <= '0;
      r_ovf           <= 1'b0;
      r_irq_en        <= 1'b0;
      r_flush_pending <= 1'b0;
      r_irq           <= 1'b0;
    end else begin
      r_rvalid <= bus_gnt_o;
      r_rdata  <= w_rdata_nxt;

      // Set beats the read-to-clear when both land together.
      if (w_data_wr && w_full) r_ovf <= 1'b1;
      else if (w_status_rd)    r_ovf <= 1'b0;

      if (w_ctrl_wr) r_irq_en <= bus_wdata_i[CTRL_IRQ_EN_BIT];

      if (w_pop)                             r_flush_pending <= 1'b0;
      else if (w_flush_req && r_state == REQ) r_flush_pending <= 1'b1;

      r_irq <= r_irq_en && w_empty && (r_state == IDLE) && !r_flush_pending;
    end
  end

  assign bus_rvalid_o = r_rvalid;
  assign bus_rdata_o  = r_rdata;
  assign empty_irq_o  = r_irq;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: instance 0 drops on full, instance 1 stalls on full.
// A queue-style reference model is compared against both DUTs every cycle.
module tb_uart_tx_buffer;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] BASE   = 32'h2000_0000;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;
  localparam logic [31:0] A_UNM  = BASE + 32'hC;
  localparam logic [31:0] UADDR  = 32'h1000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        wack  [2];
  logic        gnt   [2];
  logic        rvalid[2];
  logic [31:0] rdata [2];
  logic [31:0] uaddr [2];
  logic [7:0]  uwdata[2];
  logic        wreq  [2];
  logic        irq   [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  uart_tx_buffer #(.DEPTH(DEPTH), .BASE_ADDRESS(BASE), .UART_WRITE_ADDRESS(UADDR),
                   .STALL_ON_FULL(1'b0)) u_drop (
    .clk_i(clk), .rst_ni(rst_n),
    .bus_req_i(req[0]), .bus_we_i(we[0]), .bus_addr_i(addr[0]), .bus_wdata_i(wdata[0]),
    .bus_gnt_o(gnt[0]), .bus_rvalid_o(rvalid[0]), .bus_rdata_o(rdata[0]),
    .uart_addr_o(uaddr[0]), .uart_wdata_o(uwdata[0]), .uart_wreq_o(wreq[0]),
    .uart_wack_i(wack[0]), .empty_irq_o(irq[0]));

  uart_tx_buffer #(.DEPTH(DEPTH), .BASE_ADDRESS(BASE), .UART_WRITE_ADDRESS(UADDR),
                   .STALL_ON_FULL(1'b1)) u_stall (
    .clk_i(clk), .rst_ni(rst_n),
    .bus_req_i(req[1]), .bus_we_i(we[1]), .bus_addr_i(addr[1]), .bus_wdata_i(wdata[1]),
    .bus_gnt_o(gnt[1]), .bus_rvalid_o(rvalid[1]), .bus_rdata_o(rdata[1]),
    .uart_addr_o(uaddr[1]), .uart_wdata_o(uwdata[1]), .uart_wreq_o(wreq[1]),
    .uart_wack_i(wack[1]), .empty_irq_o(irq[1]));

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Reference model: circular byte store plus a busy flag meaning "a byte is offered to the uart".
  logic [7:0]  mbuf [2][DEPTH];
  int          mhd  [2];
  int          mcnt [2];
  bit          mbusy[2];
  bit          mfp  [2];
  bit          movf [2];
  bit          mien [2];
  bit          mirq [2];
  bit          mrv  [2];
  logic [31:0] mrd  [2];

  function automatic bit exp_gnt(input int i);
    return req[i] && !(i == 1 && we[i] && addr[i] == A_DATA && mcnt[i] == DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mhd[i] = 0; mcnt[i] = 0; mbusy[i] = 0; mfp[i] = 0;
        movf[i] = 0; mien[i] = 0; mirq[i] = 0; mrv[i] = 0; mrd[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit g, dw, sr, cw, fl, fnow, pop, full, empty, nbusy, nfp, nirq;
        logic [31:0] rd;
        full  = (mcnt[i] == DEPTH);
        empty = (mcnt[i] == 0);
        g     = exp_gnt(i);
        dw    = g && we[i] && addr[i] == A_DATA;
        sr    = g && !we[i] && addr[i] == A_STAT;
        cw    = g && we[i] && addr[i] == A_CTRL;
        fl    = cw && wdata[i][0];
        fnow  = fl && !mbusy[i];
        pop   = mbusy[i] && wack[i];
        rd    = '0;
        if (g && !we[i]) begin
          if (addr[i] == A_STAT)
            rd = {19'b0, mien[i], mbusy[i], movf[i], full, empty, 8'(mcnt[i])};
          else if (addr[i] == A_CTRL)
            rd = {30'b0, mien[i], 1'b0};
        end
        nirq  = mien[i] && empty && !mbusy[i] && !mfp[i];
        nbusy = mbusy[i] ? !pop : (!empty && !fnow);
        nfp   = pop ? 1'b0 : ((fl && mbusy[i]) ? 1'b1 : mfp[i]);
        if (pop) begin
          mhd[i]  = (mhd[i] + 1) % DEPTH;
          mcnt[i] = mcnt[i] - 1;
        end
        if (dw && !full && !fnow) begin
          mbuf[i][(mhd[i] + mcnt[i]) % DEPTH] = wdata[i][7:0];
          mcnt[i] = mcnt[i] + 1;
        end
        if (fnow || (pop && (mfp[i] || fl))) mcnt[i] = 0;
        if (dw && full)  movf[i] = 1'b1;
        else if (sr)     movf[i] = 1'b0;
        if (cw) mien[i] = wdata[i][1];
        mbusy[i] = nbusy;
        mfp[i]   = nfp;
        mirq[i]  = nirq;
        mrv[i]   = g;
        mrd[i]   = rd;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("gnt", i, 32'(gnt[i]), 32'(exp_gnt(i)));
        chk("rvalid", i, 32'(rvalid[i]), 32'(mrv[i]));
        if (mrv[i]) chk("rdata", i, rdata[i], mrd[i]);
        chk("wreq", i, 32'(wreq[i]), 32'(mbusy[i]));
        if (mbusy[i]) chk("uart_wdata", i, 32'(uwdata[i]), 32'(mbuf[i][mhd[i]]));
        chk("irq", i, 32'(irq[i]), 32'(mirq[i]));
        chk("uart_addr", i, uaddr[i], UADDR);
      end
    end
  end

  // Bytes actually accepted by the uart side, taken from the DUT pins.
  logic [7:0] dlog0[$];
  logic [7:0] dlog1[$];
  always @(posedge clk) begin
    if (rst_n && wreq[0] && wack[0]) dlog0.push_back(uwdata[0]);
    if (rst_n && wreq[1] && wack[1]) dlog1.push_back(uwdata[1]);
  end

  task automatic bus_acc(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] rd);
    int n;
    n = 0;
    req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
    @(negedge clk);
    while (!gnt[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!gnt[i]) chk("grant_timeout", i, 32'(gnt[i]), 32'd1);
    @(posedge clk); #1;
    req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    rd = rdata[i];
  endtask

  task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus_acc(i, 1'b1, a, d, unused_rd);
  endtask

  task automatic rd_chk(input string nm, input int i, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_acc(i, 1'b0, a, 32'h0, v);
    chk(nm, i, v, exp);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while ((mcnt[i] != 0 || mbusy[i]) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) chk("drain_timeout", i, 32'(mcnt[i]), 32'd0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; addr[i] = '0; wdata[i] = '0; wack[i] = 0;
    end
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    step(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_rvalid", i, 32'(rvalid[i]), 32'd0);
      chk("rst_wreq", i, 32'(wreq[i]), 32'd0);
      chk("rst_irq", i, 32'(irq[i]), 32'd0);
      chk("rst_uaddr", i, uaddr[i], 32'h1000_0000);
    end
    rst_n = 1'b1;
    step(1);

    // Single byte with the uart always acknowledging.
    wack[1] = 1'b1;
    wr(1, A_DATA, 32'h61);
    chk("t1_wreq_early", 1, 32'(wreq[1]), 32'd0);
    step(1);
    chk("t1_wreq", 1, 32'(wreq[1]), 32'd1);
    chk("t1_wdata", 1, 32'(uwdata[1]), 32'h61);
    wait_idle(1);
    rd_chk("t1_status", 1, A_STAT, 32'h0000_0100);
    chk("t1_log_len", 1, 32'(dlog1.size()), 32'd1);
    if (dlog1.size() > 0) chk("t1_log", 1, 32'(dlog1[0]), 32'h61);

    // Fill to full with the uart stalled; the 17th write must wait for the first ack.
    wack[1] = 1'b0;
    dlog1.delete();
    for (int b = 0; b < 16; b++) wr(1, A_DATA, 32'(b));
    rd_chk("t2_status_full", 1, A_STAT, 32'h0000_0A10);
    fork
      wr(1, A_DATA, 32'h10);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("t2_stall_gnt", 1, 32'(gnt[1]), 32'd0);
        end
        @(posedge clk); #1;
        wack[1] = 1'b1;
      end
    join
    wait_idle(1);
    chk("t2_log_len", 1, 32'(dlog1.size()), 32'd17);
    for (int k = 0; k < 17; k++)
      if (k < dlog1.size()) chk("t2_log", 1, 32'(dlog1[k]), 32'(k));

    // Drop-on-full instance: overflow flag, read-to-clear, dropped byte never sent.
    dlog0.delete();
    for (int b = 0; b < 16; b++) wr(0, A_DATA, 32'(b));
    wr(0, A_DATA, 32'hAA);
    rd_chk("t3_status_ovf", 0, A_STAT, 32'h0000_0E10);
    rd_chk("t3_status_clr", 0, A_STAT, 32'h0000_0A10);
    wack[0] = 1'b1;
    wait_idle(0);
    chk("t3_log_len", 0, 32'(dlog0.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      if (k < dlog0.size()) chk("t3_log", 0, 32'(dlog0[k]), 32'(k));
    wr(0, A_UNM, 32'hFF);
    rd_chk("t3_unmapped", 0, A_UNM, 32'h0);
    rd_chk("t3_status_idle", 0, A_STAT, 32'h0000_0100);

    // Push and pop together at count 5, then 40 bytes through the wrapping pointers.
    wack[1] = 1'b0;
    dlog1.delete();
    for (int b = 0; b < 5; b++) wr(1, A_DATA, 32'h20 + 32'(b));
    rd_chk("t4_status5", 1, A_STAT, 32'h0000_0805);
    wack[1] = 1'b1;
    wr(1, A_DATA, 32'h25);
    wack[1] = 1'b0;
    rd_chk("t4_status_pp", 1, A_STAT, 32'h0000_0005);
    wack[1] = 1'b1;
    for (int b = 6; b < 40; b++) wr(1, A_DATA, 32'h20 + 32'(b));
    wait_idle(1);
    chk("t4_log_len", 1, 32'(dlog1.size()), 32'd40);
    for (int k = 0; k < 40; k++)
      if (k < dlog1.size()) chk("t4_log", 1, 32'(dlog1[k]), 32'h20 + 32'(k));

    // Flush while a byte is in flight.
    wack[0] = 1'b0;
    dlog0.delete();
    wr(0, A_DATA, 32'h31);
    wr(0, A_DATA, 32'h32);
    wr(0, A_DATA, 32'h33);
    wr(0, A_CTRL, 32'h1);
    rd_chk("t5_status_pend", 0, A_STAT, 32'h0000_0803);
    wack[0] = 1'b1;
    wait_idle(0);
    step(4);
    rd_chk("t5_status_done", 0, A_STAT, 32'h0000_0100);
    chk("t5_log_len", 0, 32'(dlog0.size()), 32'd1);
    if (dlog0.size() > 0) chk("t5_log", 0, 32'(dlog0[0]), 32'h31);

    // Empty interrupt, then reset in the middle of a request.
    wack[0] = 1'b0;
    wr(0, A_CTRL, 32'h2);
    rd_chk("t6_ctrl0", 0, A_CTRL, 32'h2);
    chk("t6_irq0_on", 0, 32'(irq[0]), 32'd1);
    wack[1] = 1'b0;
    wr(1, A_CTRL, 32'h2);
    rd_chk("t6_ctrl1", 1, A_CTRL, 32'h2);
    chk("t6_irq1_on", 1, 32'(irq[1]), 32'd1);
    wr(1, A_DATA, 32'h77);
    step(2);
    chk("t6_irq_busy", 1, 32'(irq[1]), 32'd0);
    chk("t6_wreq", 1, 32'(wreq[1]), 32'd1);
    wack[1] = 1'b1;
    step(1);
    wack[1] = 1'b0;
    chk("t6_irq_lag", 1, 32'(irq[1]), 32'd0);
    step(1);
    chk("t6_irq_back", 1, 32'(irq[1]), 32'd1);
    wr(1, A_DATA, 32'h78);
    step(1);
    chk("t6_wreq_pre_rst", 1, 32'(wreq[1]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_wreq", 1, 32'(wreq[1]), 32'd0);
    chk("t6_rst_irq1", 1, 32'(irq[1]), 32'd0);
    chk("t6_rst_irq0", 0, 32'(irq[0]), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(1);
    rd_chk("t6_status_after", 1, A_STAT, 32'h0000_0100);
    rd_chk("t6_ctrl_after", 0, A_CTRL, 32'h0);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
